// File: rtl/fpu_sequencer.sv
// Multicycle FP-operation sequencer: issues one op to the FPU, waits for fpu_valid, then writes back.
// Define FPU_TIMEOUT_EN to add a WAIT timeout with an ABORT cycle and a sticky err flag.
module fpu_sequencer #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [3:0]       op_in,
  input  logic             mode_in,
  input  logic             srca_int_in,
  input  logic             dest_int_in,
  input  logic             fpu_valid,
  output logic             fpu_go,
  output logic [3:0]       fpucontrol,
  output logic             mode,
  output logic             fpusrca,
  output logic             fregwrite,
  output logic [1:0]       fregsrc,
  output logic             regwrite,
  output logic [2:0]       regsrc,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] wait_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
`ifdef FPU_TIMEOUT_EN
    S_ABORT,
`endif
    S_WB
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       op_reg;
  logic             mode_reg, srca_reg, dest_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] wait_reg;
  logic             ctrl_en;

`ifdef FPU_TIMEOUT_EN
  logic err_reg;
  logic timeout_hit;
  assign timeout_hit = (state_reg == S_WAIT) && !fpu_valid &&
                       (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= S_IDLE;
      op_reg    <= '0;
      mode_reg  <= 1'b0;
      srca_reg  <= 1'b0;
      dest_reg  <= 1'b0;
      cnt_reg   <= '0;
      wait_reg  <= '0;
`ifdef FPU_TIMEOUT_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg   <= op_in;
            mode_reg <= mode_in;
            srca_reg <= srca_int_in;
            dest_reg <= dest_int_in;
            cnt_reg  <= '0;
`ifdef FPU_TIMEOUT_EN
            err_reg  <= 1'b0;
`endif
          end
        end
        S_WAIT: begin
          // Saturate so a very long wait reports all-ones instead of wrapping.
          if (cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
`ifdef FPU_TIMEOUT_EN
          if (timeout_hit) err_reg <= 1'b1;
`endif
        end
        S_WB: wait_reg <= cnt_reg;
`ifdef FPU_TIMEOUT_EN
        S_ABORT: wait_reg <= CNT_W'(TIMEOUT_CYCLES);
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    fpu_go     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    ctrl_en    = 1'b0;
    fregwrite  = 1'b0;
    fregsrc    = 2'd0;
    regwrite   = 1'b0;
    regsrc     = 3'd0;
    case (state_reg)
      S_IDLE: if (start) state_next = S_ISSUE;
      S_ISSUE: begin
        fpu_go     = 1'b1;
        busy       = 1'b1;
        ctrl_en    = 1'b1;
        state_next = fpu_valid ? S_WB : S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        ctrl_en = 1'b1;
        if (fpu_valid) state_next = S_WB;
`ifdef FPU_TIMEOUT_EN
        else if (timeout_hit) state_next = S_ABORT;
`endif
      end
      S_WB: begin
        busy    = 1'b1;
        ctrl_en = 1'b1;
        done    = 1'b1;
        if (dest_reg) begin
          regwrite = 1'b1;
          regsrc   = 3'd6;
        end else begin
          fregwrite = 1'b1;
          fregsrc   = 2'd3;
        end
        state_next = S_IDLE;
      end
`ifdef FPU_TIMEOUT_EN
      S_ABORT: begin
        busy       = 1'b1;
        ctrl_en    = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  assign fpucontrol  = ctrl_en ? op_reg : 4'd0;
  assign mode        = ctrl_en & mode_reg;
  assign fpusrca     = ctrl_en & srca_reg;
  assign wait_cycles = wait_reg;

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer: transaction-level model (cycles since accepted start) plus directed literal checks.
module tb_fpu_sequencer;
  localparam int TO = 8;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic [3:0]    op_in = 4'd0;
  logic          mode_in = 1'b0, srca_int_in = 1'b0, dest_int_in = 1'b0, fpu_valid = 1'b0;
  logic          fpu_go, mode, fpusrca, fregwrite, regwrite, busy, done, err;
  logic [3:0]    fpucontrol;
  logic [1:0]    fregsrc;
  logic [2:0]    regsrc;
  logic [CW-1:0] wait_cycles;

  int tests = 0;
  int fails = 0;

  fpu_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op_in(op_in), .mode_in(mode_in),
    .srca_int_in(srca_int_in), .dest_int_in(dest_int_in), .fpu_valid(fpu_valid),
    .fpu_go(fpu_go), .fpucontrol(fpucontrol), .mode(mode), .fpusrca(fpusrca),
    .fregwrite(fregwrite), .fregsrc(fregsrc), .regwrite(regwrite), .regsrc(regsrc),
    .busy(busy), .done(done), .err(err), .wait_cycles(wait_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an op is "active" from the accepted start; m_t counts cycles since then (1 = launch cycle),
  // m_vt is the cycle in which the first fpu_valid was seen (0 = not yet).
  bit       m_active, m_mode, m_srca, m_dest, m_err;
  int       m_t, m_vt, m_wait;
  bit [3:0] m_op;

  function automatic bit m_wb();
    return m_active && (m_vt != 0) && (m_t == m_vt + 1);
  endfunction

  function automatic bit m_abort();
`ifdef FPU_TIMEOUT_EN
    return m_active && (m_vt == 0) && (m_t == TO + 2);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_active <= 0; m_t <= 0; m_vt <= 0; m_op <= 0;
      m_mode <= 0; m_srca <= 0; m_dest <= 0; m_err <= 0; m_wait <= 0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1; m_t <= 1; m_vt <= 0; m_op <= op_in;
        m_mode <= mode_in; m_srca <= srca_int_in; m_dest <= dest_int_in; m_err <= 0;
      end
    end else if (m_wb() || m_abort()) begin
      m_active <= 0;
      m_wait   <= m_wb() ? ((m_vt - 1 > 127) ? 127 : m_vt - 1) : TO;
    end else begin
      if (m_vt == 0 && fpu_valid) m_vt <= m_t;
`ifdef FPU_TIMEOUT_EN
      if (m_vt == 0 && !fpu_valid && m_t == TO + 1) m_err <= 1;
`endif
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin : cmp
    bit wb, ab;
    wb = m_wb();
    ab = m_abort();
    chk("busy", busy, m_active);
    chk("fpu_go", fpu_go, m_active && m_t == 1);
    chk("done", done, wb || ab);
    chk("fregwrite", fregwrite, wb && !m_dest);
    chk("fregsrc", fregsrc, (wb && !m_dest) ? 3 : 0);
    chk("regwrite", regwrite, wb && m_dest);
    chk("regsrc", regsrc, (wb && m_dest) ? 6 : 0);
    chk("fpucontrol", fpucontrol, m_active ? m_op : 4'd0);
    chk("mode", mode, m_active && m_mode);
    chk("fpusrca", fpusrca, m_active && m_srca);
    chk("err", err, m_err);
    chk("wait_cycles", wait_cycles, m_wait);
  end

  // vdel: valid asserted vdel cycles after launch (0 = during launch); negative = never.
  task automatic run_op(input logic [3:0] op, input logic m, input logic s, input logic d,
                        input int vdel, input bit noise, output int done_cyc);
    start = 1; op_in = op; mode_in = m; srca_int_in = s; dest_int_in = d;
    @(posedge clk); #1;
    start = 0;
    done_cyc = -1;
    for (int c = 1; c <= 300; c++) begin
      fpu_valid = (vdel >= 0 && c == vdel + 1);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        op_in = 4'($urandom);
        mode_in = 1'($urandom); srca_int_in = 1'($urandom); dest_int_in = 1'($urandom);
      end
      @(negedge clk);
      if (done) done_cyc = c;
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    start = 0; fpu_valid = 0;
    if (done_cyc < 0) chk("op_completion_timeout", 0, 1);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      start = 0;
      fpu_valid = 1'($urandom);
      @(posedge clk); #1;
    end
    fpu_valid = 0;
  endtask

  initial begin
    int dc;
    #2 rstn = 0;
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    chk("rst_busy", busy, 0);
    chk("rst_wait", wait_cycles, 0);

    run_op(4'd1, 0, 0, 0, 3, 0, dc);
    chk("t1_done_cycle", dc, 5);
    chk("t1_wait_cycles", wait_cycles, 3);
    chk("t1_busy_after", busy, 0);

    run_op(4'd9, 0, 0, 1, 0, 0, dc);
    chk("t2_done_cycle", dc, 2);
    chk("t2_wait_cycles", wait_cycles, 0);

    run_op(4'd5, 1, 1, 0, 2, 0, dc);
    chk("t3_done_cycle", dc, 4);
    chk("t3_mode_idle", mode, 0);
    chk("t3_fpusrca_idle", fpusrca, 0);

    run_op(4'd7, 0, 1, 1, 4, 1, dc);
    chk("t4_done_cycle", dc, 6);
    chk("t4_wait_cycles", wait_cycles, 4);
    idle_gap(3);

    // Reset while waiting on the FPU
    start = 1; op_in = 4'd3; mode_in = 1; srca_int_in = 1; dest_int_in = 0;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #3 rstn = 0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_fpucontrol", fpucontrol, 0);
    chk("t5_writes", {fregwrite, regwrite, done, fpu_go}, 0);
    fpu_valid = 1;
    @(posedge clk); #1 rstn = 1;
    repeat (3) @(posedge clk);
    #1 fpu_valid = 0;
    chk("t5_busy_after", busy, 0);

`ifdef FPU_TIMEOUT_EN
    run_op(4'd2, 0, 0, 0, -1, 0, dc);
    chk("to_done_cycle", dc, TO + 2);
    chk("to_err", err, 1);
    chk("to_wait_cycles", wait_cycles, TO);
    run_op(4'd4, 0, 0, 1, 1, 0, dc);
    chk("to_err_cleared", err, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      int vd;
      vd = $urandom_range(0, 12);
`ifdef FPU_TIMEOUT_EN
      if ($urandom_range(0, 7) == 0) vd = -1;
`endif
      run_op(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), vd, 1'($urandom), dc);
      chk("rand_done_cycle", dc, (vd < 0) ? TO + 2 : vd + 2);
      idle_gap($urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end
endmodule

// File: doc/fpu_sequencer.md
Name: fpu_sequencer

Overview:
- Multicycle controller for the floating-point half of the core datapath.
- Main control FSM hands over one FP operation via a start pulse. This block issues it to the FPU (fpu_go), holds FPU control steady, and waits for fpu_valid.
- It then performs the register-file writeback: float file via the FPU-result path, or int file for compare/convert results. Finally it pulses done so the main FSM can resume fetch.
- Main FSM holds pcen low while busy=1.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before aborting (only with FPU_TIMEOUT_EN)
CNT_W, 7, width of wait counter; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  core clock
rstn  input  1  asynchronous active-low reset
start  input  1  one-cycle request from main FSM
op_in  input  4  FPU operation code, passed to fpucontrol
mode_in  input  1  FPU mode bit for this op
srca_int_in  input  1  1 = operand A from int register (int-to-float)
dest_int_in  input  1  1 = result to int register file, 0 = float file
fpu_valid  input  1  FPU result valid
fpu_go  output  1  one-cycle FPU launch
fpucontrol  output  4  FPU operation code
mode  output  1  FPU mode
fpusrca  output  1  FPU operand-A select
fregwrite  output  1  float register-file write enable
fregsrc  output  2  float write-data select; 2'd3 = FPU result register
regwrite  output  1  int register-file write enable
regsrc  output  3  int write-data select; 3'd6 = FPU result register
busy  output  1  operation in flight
done  output  1  one-cycle completion pulse
err  output  1  sticky timeout flag
wait_cycles  output  CNT_W  cycles spent waiting on last op (perf)

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; all outputs 0; captured op/mode/srca/dest registers 0; wait counter 0.
- States:
  - IDLE: busy=0. If start=1, capture op_in, mode_in, srca_int_in, dest_int_in; clear err; counter 0; next ISSUE.
  - ISSUE: fpu_go=1 (exactly one cycle); fpucontrol/mode/fpusrca driven from captured values. If fpu_valid=1 this cycle, next WB; else next WAIT.
  - WAIT: fpucontrol/mode/fpusrca held; fpu_go=0; counter increments each cycle, saturating at all-ones. If fpu_valid=1, next WB.
  - WB: one cycle, fpu_go=0.
    - dest=0: fregwrite=1, fregsrc=2'd3.
    - dest=1: regwrite=1, regsrc=3'd6.
    - done=1; wait_cycles <= counter; next IDLE.
- busy=1 in ISSUE, WAIT and WB.
- fpucontrol/mode/fpusrca are held from ISSUE through WB; they return to 0 in IDLE.
- The FPU result register captures fpuresult on the fpu_valid edge, so WB reads a stable value.
- Latency: start sampled at edge 0 → ISSUE cycle 1 → WB/done no earlier than cycle 2. If valid arrives in WAIT cycle k, WB is cycle k+1.
- start while busy: ignored; captured values unchanged.
- start in the same cycle as done (WB): ignored; the main FSM re-requests from IDLE.
- fpu_valid in IDLE or WB: ignored.
- fregwrite and regwrite are never both 1. Neither is ever asserted outside WB.
- Reset mid-operation: immediate return to IDLE; no write enable or done generated afterward.

Optional Feature:
- FPU_TIMEOUT_EN defined:
  - In WAIT, if counter == TIMEOUT_CYCLES-1 and fpu_valid=0, go to IDLE through an ABORT cycle.
  - ABORT asserts done=1 and sets err=1; no fregwrite/regwrite; wait_cycles <= TIMEOUT_CYCLES.
  - err stays set until the next accepted start or reset.
- FPU_TIMEOUT_EN undefined: WAIT waits indefinitely; err is tied to 0; no ABORT state exists.

Test Plan:
- op_in=4'd1, dest=0, fpu_valid pulsed 3 cycles after ISSUE → fpu_go high exactly one cycle; fregwrite=1, fregsrc=2 'd3 one cycle after valid; done same cycle; wait_cycles=3; busy cleared next cycle.
- dest=1, srca=0, fpu_valid=1 during ISSUE → WB at cycle 2; regwrite=1, regsrc=3'd6; fregwrite stays 0; wait_cycles=0.
- srca_int_in=1, mode_in=1 → fpusrca=1 and mode=1 held from ISSUE through WB; both 0 after return to IDLE.
- Second start asserted during WAIT and during WB → ignored; exactly one done; captured op unchanged.
- rstn low during WAIT → all outputs 0 immediately; later fpu_valid produces no write or done.
- FPU_TIMEOUT_EN, TIMEOUT_CYCLES=8, valid never asserted → done=1 and err=1 after 8 WAIT cycles; no write enables; next start clears err.
